disp_scan: RTL

- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Holds a NUM_DIGITS-nibble display word and cycles through the digits, one at a time.
- Drives the active nibble on disp_val to the downstream hex-to-segment decoder, plus active-low anode enables and the decimal point.
- New words are loaded through a shadow register and applied only at a frame boundary, so a displayed number never tears mid-frame.

---
 rtl/disp_scan.sv | 133 +++++++++++++
 1 files changed

// File: rtl/disp_scan.sv
`default_nettype none
// disp_scan: time-multiplexed common-anode 7-segment scanner with per-slot
// anti-ghost dead time and frame-synchronous (tear-free) word update.
module disp_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              disp_val,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    dp_out,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);

  localparam logic [CNT_W-1:0] DEAD_LEN = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] ON_LEN   = CNT_W'(REFRESH_DIV - BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_DEAD = 1'b0;
  localparam logic [0:0] ST_ON   = 1'b1;

  logic [0:0]              state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    en_smp, en_smp_nxt;
  logic                    dp_smp, dp_smp_nxt;
  logic [4*NUM_DIGITS-1:0] active, active_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic                    pending_nxt;
  logic [3:0]              disp_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;
  logic                    fd_nxt;

  // cnt holds the 1-based position inside the current state; reset leaves it
  // at 0 so the first DEAD period after reset lasts one extra cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_DEAD;
      cnt        <= '0;
      idx        <= '0;
      en_smp     <= 1'b0;
      dp_smp     <= 1'b0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      disp_val   <= 4'd0;
      an_out     <= '1;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      en_smp     <= en_smp_nxt;
      dp_smp     <= dp_smp_nxt;
      active     <= active_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      disp_val   <= disp_nxt;
      an_out     <= an_nxt;
      dp_out     <= dp_nxt;
      frame_done <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_ONE;
    idx_nxt    = idx;
    en_smp_nxt = en_smp;
    dp_smp_nxt = dp_smp;
    case (state)
      ST_DEAD: begin
        if (cnt >= DEAD_LEN) begin
          state_nxt  = ST_ON;
          cnt_nxt    = CNT_ONE;
          en_smp_nxt = digit_en[idx];
          dp_smp_nxt = dp_in[idx];
        end
      end
      default: begin
        if (cnt >= ON_LEN) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = CNT_ONE;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
      end
    endcase
  end

  // frame_done marks the boundary cycle; a load landing on it bypasses the shadow.
  always_comb begin
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (frame_done) begin
      if (load) begin
        active_nxt = value_in;
        shadow_nxt = value_in;
      end else if (pending) begin
        active_nxt = shadow;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      shadow_nxt  = value_in;
      pending_nxt = 1'b1;
    end
  end

  always_comb begin
    disp_nxt = active_nxt[{idx, 2'b00} +: 4];
    an_nxt   = '1;
    if (state == ST_ON && en_smp) begin
      an_nxt[idx] = 1'b0;
    end
    dp_nxt = (state == ST_ON) && dp_smp;
    fd_nxt = (state == ST_ON) && (cnt == ON_LEN) && (idx == LAST_IDX);
  end

endmodule
`default_nettype wire
